// File: rtl/multiplier_4bit_seq.sv
// multiplier_4bit_seq
//
// Sequential shift-add unsigned multiplier. It is the companion to the ALU's
// combinational divider in the 8-bit processor datapath. The ALU control FSM
// issues MUL with a start pulse and stalls while busy is high.
//
// One multiplier bit is consumed per clock. A request accepted at edge E0
// raises done for one cycle after edge E0+WIDTH. The next request can be
// accepted at edge E0+WIDTH+2.
//
// Ports:
//   clk      rising-edge system clock
//   reset    asynchronous, active-high reset; aborts any operation in flight
//   start    request; only sampled in IDLE
//   A_input  multiplicand (WIDTH bits, unsigned), captured at start
//   B_input  multiplier   (WIDTH bits, unsigned), captured at start
//   product  registered 2*WIDTH-bit result; holds the last result until the
//            next completion
//   busy     high in RUN and DONE
//   done     one-cycle strobe; product is valid in the same cycle
//
// Optional build macro MULT_EARLY_TERM_EN:
//   When defined, RUN ends as soon as the remaining multiplier bits are all
//   zero, so latency becomes max(1, msb_index(B_input)+1) cycles. Products are
//   identical in both builds.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; busy=0, done=0
// RUN   | one shift-add iteration per clock; product held
// DONE  | product just updated; done=1 for this single cycle, busy=1

module multiplier_4bit_seq #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     A_input,
  input  logic [WIDTH-1:0]     B_input,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [PW-1:0]     acc;
  logic [PW-1:0]     mcand;
  logic [WIDTH-1:0]  mplier;
  logic [CW-1:0]     count;

  logic [PW-1:0]     acc_sum;
  logic [WIDTH-1:0]  mplier_shr;
  logic              last_iter;

  // Partial product for this iteration. mcand is zero-extended to 2*WIDTH
  // bits and the running sum never exceeds (2^WIDTH-1)^2, so no carry-out.
  always_comb begin
    acc_sum    = mplier[0] ? (acc + mcand) : acc;
    mplier_shr = mplier >> 1;
  end

`ifdef MULT_EARLY_TERM_EN
  // Stop once no set multiplier bits remain; further iterations add nothing.
  always_comb begin
    last_iter = (count == CW'(WIDTH - 1)) || (mplier_shr == '0);
  end
`else
  always_comb begin
    last_iter = (count == CW'(WIDTH - 1));
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand  <= {{WIDTH{1'b0}}, A_input};
            mplier <= B_input;
            acc    <= '0;
            count  <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end

        RUN: begin
          acc    <= acc_sum;
          mcand  <= mcand << 1;
          mplier <= mplier_shr;
          count  <= count + CW'(1);
          if (last_iter) begin
            // Final value includes this iteration's add.
            product <= acc_sum;
            done    <= 1'b1;
            state   <= DONE;
          end
        end

        DONE: begin
          // start is deliberately not looked at here; it must be reasserted
          // once the block is back in IDLE.
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
